// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command-side controller (alu_issue_ctrl).
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 13;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned CMD_W      = OP_W + 2 * ALU_DATA_W;

  localparam logic [OP_W-1:0] OP_PASS = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV  = 3'b011;
  localparam logic [OP_W-1:0] OP_MOD  = 3'b100;
  localparam logic [OP_W-1:0] OP_GT   = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b111;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [ALU_DATA_W-1:0] x;
    logic [ALU_DATA_W-1:0] y;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } alu_state_t;

  // Division or modulo with a zero divisor.
  function automatic logic is_divz(input alu_cmd_t c);
    return ((c.op == OP_DIV) || (c.op == OP_MOD)) && (c.y == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO: power-of-two depth, wrapping pointers plus an occupancy count.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [CMD_W-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CMD_W-1:0] o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered commands to a clocked ALU one at a time and returns tagged results.
// Optional divide/modulo-by-zero short-circuit: define ALU_ISSUE_DIVZ_GUARD_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = ALU_DATA_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_x,
  input  logic [DATA_W-1:0] cmd_y,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_status,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_status,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_err
);

  localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

  alu_state_t       r_state;
  alu_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_capture;
  logic             w_rsp_drop;
  logic             w_guard_hit;
  logic [CMD_W-1:0] w_head_vec;
  alu_cmd_t         w_head;
  alu_cmd_t         w_cmd_in;

  logic [OP_W-1:0]   r_alu_opcode;
  logic [DATA_W-1:0] r_alu_x;
  logic [DATA_W-1:0] r_alu_y;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_status;
  logic [OP_W-1:0]   r_rsp_op;

  assign w_cmd_in  = '{op: cmd_op, x: cmd_x, y: cmd_y};
  assign w_head    = alu_cmd_t'(w_head_vec);
  assign cmd_ready = !rst && !w_full;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .aclk        (aclk),
    .rst         (rst),
    .i_push      (cmd_valid),
    .i_push_data (w_cmd_in),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head_vec)
  );

`ifdef ALU_ISSUE_DIVZ_GUARD_EN
  assign w_guard_hit = is_divz(w_head);
`else
  assign w_guard_hit = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; a pop from IDLE or from a RESP handshake always lands in WAIT or RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_rsp_drop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_pop = 1'b1;
      end
      ST_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_drop = 1'b1;
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_pop) begin
      if (w_guard_hit) begin
        w_state_nxt = ST_RESP;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = CNT_W'(ALU_LAT);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_alu_opcode <= '0;
      r_alu_x      <= '0;
      r_alu_y      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_status <= 1'b0;
      r_rsp_op     <= '0;
    end else begin
      if (w_pop) begin
        r_alu_opcode <= w_head.op;
        r_alu_x      <= w_head.x;
        r_alu_y      <= w_head.y;
      end
      if (w_capture) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= alu_result;
        r_rsp_status <= alu_status;
        r_rsp_op     <= r_alu_opcode;
      end else if (w_pop && w_guard_hit) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= '0;
        r_rsp_status <= 1'b1;
        r_rsp_op     <= w_head.op;
      end else if (w_rsp_drop) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_DIVZ_GUARD_EN
  logic r_rsp_err;

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_rsp_err <= 1'b0;
    end else if (w_capture) begin
      r_rsp_err <= 1'b0;
    end else if (w_pop && w_guard_hit) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign alu_opcode = r_alu_opcode;
  assign alu_x      = r_alu_x;
  assign alu_y      = r_alu_y;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_status = r_rsp_status;
  assign rsp_op     = r_rsp_op;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered one-cycle ALU model attached.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  localparam int unsigned DW = 13;

  logic          aclk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_x;
  logic [DW-1:0] cmd_y;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_x;
  logic [DW-1:0] alu_y;
  logic [DW-1:0] alu_result;
  logic          alu_status;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_status;
  logic [2:0]    rsp_op;
  logic          rsp_err;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] res;
    logic          st;
    logic          err;
  } rsp_t;

  rsp_t q_exp[$];

  alu_issue_ctrl #(.DATA_W(DW), .DEPTH(4), .ALU_LAT(1)) dut (
    .aclk       (aclk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .alu_opcode (alu_opcode),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_result (alu_result),
    .alu_status (alu_status),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_status (rsp_status),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
    case (op)
      3'd0:    return x;
      3'd1:    return x + y;
      3'd2:    return x - y;
      3'd3:    return (y == '0) ? {DW{1'b1}} : x / y;
      3'd4:    return (y == '0) ? x : x % y;
      3'd5:    return (x > y) ? DW'(1) : DW'(0);
      3'd6:    return x >> y;
      default: return x << y;
    endcase
  endfunction

  // Clocked ALU: one edge from operands to result.
  always @(posedge aclk) begin
    alu_result <= alu_f(alu_opcode, alu_x, alu_y);
    alu_status <= (alu_f(alu_opcode, alu_x, alu_y) == '0);
  end

  function automatic rsp_t exp_rsp(input logic [2:0] op, input logic [DW-1:0] x,
                                   input logic [DW-1:0] y);
    rsp_t r;
    r.op  = op;
    r.res = alu_f(op, x, y);
    r.st  = (r.res == '0);
    r.err = 1'b0;
`ifdef ALU_ISSUE_DIVZ_GUARD_EN
    if ((op == 3'd3 || op == 3'd4) && y == '0) begin
      r.res = '0;
      r.st  = 1'b1;
      r.err = 1'b1;
    end
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push(input logic [2:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    int t;
    t = 0;
    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    while (!cmd_ready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (cmd_ready) q_exp.push_back(exp_rsp(op, x, y));
    else check("push_timeout", 32'(cmd_ready), 32'(1));
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!rsp_valid && n < 50);
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'(1));
  endtask

  // Consumes n responses in order; with rnd, rsp_ready toggles and held data is rechecked.
  task automatic drain(input int n, input bit rnd);
    int   got;
    int   cyc;
    rsp_t e;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 2000) begin
      @(negedge aclk);
      cyc++;
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid) begin
        if (q_exp.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'(0));
        end else begin
          e = q_exp[0];
          check("rsp_result", 32'(rsp_result), 32'(e.res));
          check("rsp_status", 32'(rsp_status), 32'(e.st));
          check("rsp_op", 32'(rsp_op), 32'(e.op));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          if (rsp_ready) begin
            void'(q_exp.pop_front());
            got++;
          end
        end
      end
    end
    check("drain_count", 32'(got), 32'(n));
    @(posedge aclk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_x     = '0;
    cmd_y     = '0;
    rsp_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_alu_opcode", 32'(alu_opcode), 32'(0));
    check("rst_alu_x", 32'(alu_x), 32'(0));
    check("rst_alu_y", 32'(alu_y), 32'(0));
    check("rst_rsp_result", 32'(rsp_result), 32'(0));
    check("rst_rsp_status", 32'(rsp_status), 32'(0));
    check("rst_rsp_op", 32'(rsp_op), 32'(0));
    check("rst_rsp_err", 32'(rsp_err), 32'(0));
    rst = 1'b0;
    @(negedge aclk);
    check("ready_after_rst", 32'(cmd_ready), 32'(1));

    // Single add 5+7: valid 3 edges after accept
    push(3'd1, 13'd5, 13'd7);
    wait_rsp(lat);
    check("add_latency", 32'(lat), 32'(4));
    check("add_result", 32'(rsp_result), 32'(12));
    check("add_status", 32'(rsp_status), 32'(0));
    check("add_op", 32'(rsp_op), 32'(1));
    check("add_alu_x_held", 32'(alu_x), 32'(5));
    check("add_alu_y_held", 32'(alu_y), 32'(7));
    drain(1, 1'b0);

    // Sub 9-9 -> zero status
    push(3'd2, 13'd9, 13'd9);
    wait_rsp(lat);
    check("sub_result", 32'(rsp_result), 32'(0));
    check("sub_status", 32'(rsp_status), 32'(1));
    check("sub_op", 32'(rsp_op), 32'(2));
    drain(1, 1'b0);

    // Shl 0x1001 by 1 drops the top bit
    push(3'd7, 13'h1001, 13'd1);
    wait_rsp(lat);
    check("shl_result", 32'(rsp_result), 32'h0002);
    check("shl_status", 32'(rsp_status), 32'(0));
    check("shl_op", 32'(rsp_op), 32'(7));
    drain(1, 1'b0);

    // Divide by zero
    push(3'd3, 13'd10, 13'd0);
    wait_rsp(lat);
`ifdef ALU_ISSUE_DIVZ_GUARD_EN
    check("divz_latency", 32'(lat), 32'(2));
    check("divz_result", 32'(rsp_result), 32'(0));
    check("divz_status", 32'(rsp_status), 32'(1));
    check("divz_err", 32'(rsp_err), 32'(1));
`else
    check("divz_latency", 32'(lat), 32'(4));
    check("divz_result", 32'(rsp_result), 32'h1FFF);
    check("divz_status", 32'(rsp_status), 32'(0));
    check("divz_err", 32'(rsp_err), 32'(0));
`endif
    check("divz_op", 32'(rsp_op), 32'(3));
    drain(1, 1'b0);

    // Fill: one in flight + 4 buffered, then a refused push during a pop
    for (int i = 0; i < 5; i++) push(3'd1, 13'(i), 13'd100);
    @(negedge aclk);
    check("full_ready", 32'(cmd_ready), 32'(0));
    fork
      begin
        @(negedge aclk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_x     = 13'h1ABC;
        cmd_y     = 13'd0;
        check("full_refuse", 32'(cmd_ready), 32'(0));
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
      end
      drain(5, 1'b0);
    join
    rsp_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge aclk);
      if (rsp_valid) seen++;
    end
    check("no_extra_rsp", 32'(seen), 32'(0));
    rsp_ready = 1'b0;

    // 50 pseudo-random commands with a stalling consumer
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          push(3'($urandom_range(0, 7)), 13'($urandom_range(0, 8191)),
               (i % 7 == 0) ? 13'd0 : 13'($urandom_range(0, 20)));
        end
      end
      drain(50, 1'b1);
    join
    check("rand_queue_empty", 32'(q_exp.size()), 32'(0));

    // Reset during WAIT with 3 queued commands
    push(3'd1, 13'd10, 13'd1);
    push(3'd1, 13'd20, 13'd1);
    push(3'd1, 13'd30, 13'd1);
    push(3'd1, 13'd40, 13'd1);
    wait_rsp(lat);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_x     = 13'd50;
    cmd_y     = 13'd1;
    @(posedge aclk);
    #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("pre_rst_alu_x", 32'(alu_x), 32'(20));
    check("pre_rst_in_wait", 32'(rsp_valid), 32'(0));
    @(negedge aclk);
    rst = 1'b1;
    @(negedge aclk);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'(0));
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("mid_rst_alu_x", 32'(alu_x), 32'(0));
    check("mid_rst_alu_opcode", 32'(alu_opcode), 32'(0));
    check("mid_rst_rsp_result", 32'(rsp_result), 32'(0));
    check("mid_rst_rsp_op", 32'(rsp_op), 32'(0));
    rst = 1'b0;
    q_exp.delete();
    @(negedge aclk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));
    rsp_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge aclk);
      if (rsp_valid) seen++;
    end
    check("no_stale_rsp", 32'(seen), 32'(0));
    rsp_ready = 1'b0;
    push(3'd1, 13'd1, 13'd1);
    wait_rsp(lat);
    check("post_rst_add", 32'(rsp_result), 32'(2));
    drain(1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
